mult_rr_scheduler: RTL

// - Shares one sequential Multiplier (start/ready handshake, N-bit operands, 2N-bit product)

---
 rtl/mult_rr_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: shares one sequential start/ready multiplier among NREQ
// requesters using round-robin arbitration. The product is returned on a
// shared bus together with a one-cycle req_done pulse to the served slot.
// Optional WAIT watchdog: define MULT_SCHED_TIMEOUT_EN.
module mult_rr_scheduler #(
   parameter int unsigned N              = 8,
   parameter int unsigned NREQ           = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*N-1:0]       req_a,
   input  logic [NREQ*N-1:0]       req_b,
   output logic [NREQ-1:0]         req_done,
   output logic [2*N-1:0]          req_product,
   output logic                    req_err,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    mul_start,
   output logic [N-1:0]            mul_multiplier,
   output logic [N-1:0]            mul_multiplicand,
   input  logic                    mul_ready,
   input  logic [2*N-1:0]          mul_product
);

   localparam int unsigned IDW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  ptr_q, ptr_d;
   logic [IDW-1:0]  gid_q, gid_d;
   logic [N-1:0]    opa_q, opa_d;
   logic [N-1:0]    opb_q, opb_d;
   logic [2*N-1:0]  prod_q, prod_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            start_q, start_d;
   logic            busy_q, busy_d;

   logic            found;
   logic [IDW-1:0]  win;

`ifdef MULT_SCHED_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wcnt_q, wcnt_d;
   logic       err_q, err_d;
`endif

   // Round-robin search: first asserted slot starting at ptr, wrapping modulo NREQ
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      win   = ptr_q;
      for (int unsigned off = 0; off < NREQ; off++) begin
         idx = 32'(ptr_q) + off;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req_valid[IDW'(idx)]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   // Next-state and registered-output logic for the grant/issue/wait/respond cycle
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      prod_d  = prod_q;
      done_d  = '0;
      start_d = 1'b0;
      busy_d  = busy_q;
`ifdef MULT_SCHED_TIMEOUT_EN
      wcnt_d  = wcnt_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_ISSUE;
               gid_d   = win;
               opa_d   = req_a[32'(win)*N +: N];
               opb_d   = req_b[32'(win)*N +: N];
               start_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
            wcnt_d  = '0;
`endif
         end
         S_WAIT: begin
            if (mul_ready) begin
               prod_d  = mul_product;
               done_d  = NREQ'(1) << gid_q;
               state_d = S_RESP;
            end
`ifdef MULT_SCHED_TIMEOUT_EN
            else if (wcnt_q == TO_LAST) begin
               prod_d  = '0;
               err_d   = 1'b1;
               done_d  = NREQ'(1) << gid_q;
               state_d = S_RESP;
            end else begin
               wcnt_d  = wcnt_q + 8'd1;
            end
`endif
         end
         S_RESP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            ptr_d   = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         prod_q  <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
         wcnt_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
         start_q <= start_d;
         busy_q  <= busy_d;
`ifdef MULT_SCHED_TIMEOUT_EN
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
`endif
      end
   end

   assign req_done         = done_q;
   assign req_product      = prod_q;
   assign busy             = busy_q;
   assign grant_id         = gid_q;
   assign mul_start        = start_q;
   assign mul_multiplier   = opa_q;
   assign mul_multiplicand = opb_q;

`ifdef MULT_SCHED_TIMEOUT_EN
   assign req_err = err_q;
`else
   // Without the watchdog the error flag is constant and the limit has no effect
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign req_err        = 1'b0;
`endif

endmodule
